// File: rtl/traffic_pkg.sv
// traffic_pkg: constants and state encoding shared by the intersection
// front-end blocks.
//   CLK_HZ              - system clock frequency
//   DEBOUNCE_MS         - button debounce window
//   DEBOUNCE_CYCLES_DEF - debounce window expressed in clock cycles
//   db_state_e          - debouncer FSM states
`timescale 1ns/1ps
package traffic_pkg;
  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_MS         = 20;
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_e;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: N-flop synchroniser for a single asynchronous bit.
//   clock   - destination clock
//   reset_n - asynchronous active-low reset; every stage resets to RST_VAL
//   d       - asynchronous input
//   q       - synchronised output (last stage)
`timescale 1ns/1ps
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  // sync_q[0] captures the raw input; sync_q[STAGES-1] is the clean output
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= {STAGES{RST_VAL}};
    else          sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/car_request_sync.sv
// car_request_sync: car-sensor pushbutton front end for the intersection
// controller. Synchronises the raw active-low button, debounces both edges,
// emits a one-cycle press strobe and latches a sticky request until the
// controller clears it.
//   clock       - 50 MHz system clock
//   reset_n     - asynchronous active-low reset
//   key_n       - raw button, 0 = pressed, asynchronous
//   clear       - one-cycle "request serviced" pulse from the controller
//   car_waiting - sticky request, set by accepted press, cleared by clear
//   press_pulse - one-cycle strobe per accepted press
//   debounced   - debounced pressed level (PRESSED / RELEASE_CHK)
`timescale 1ns/1ps
module car_request_sync
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  input  logic clear,
  output logic car_waiting,
  output logic press_pulse,
  output logic debounced
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic key_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (key_n),
    .q       (key_s)
  );

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          car_waiting_q, car_waiting_d;
  logic          press_pulse_q, press_pulse_d;
  logic          debounced_q, debounced_d;
  logic          set_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RELEASED;
      cnt_q         <= '0;
      car_waiting_q <= 1'b0;
      press_pulse_q <= 1'b0;
      debounced_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      car_waiting_q <= car_waiting_d;
      press_pulse_q <= press_pulse_d;
      debounced_q   <= debounced_d;
    end
  end

  // The counter only advances while staying in a CHK state; every other
  // path (including every state change) leaves it at zero, so each state is
  // entered with a fresh count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    set_req = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!key_s) state_d = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          set_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) state_d = RELEASE_CHK;
      end
      RELEASE_CHK: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase

    press_pulse_d = set_req;
    // Level follows the next state so it rises together with press_pulse.
    debounced_d   = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    // A press arriving with clear in the same cycle keeps the request.
    car_waiting_d = set_req | (car_waiting_q & ~clear);
  end

  assign car_waiting = car_waiting_q;
  assign press_pulse = press_pulse_q;
  assign debounced   = debounced_q;
endmodule

// File: tb/tb_car_request_sync.sv
`timescale 1ns/1ps
module tb_car_request_sync;
  import traffic_pkg::*;

  logic clock = 1'b0;
  logic reset_n, key_n, clear;
  logic car_waiting, press_pulse, debounced;
  int   checks = 0;
  int   failures = 0;
  int   pulses;

  car_request_sync #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .clear       (clear),
    .car_waiting (car_waiting),
    .press_pulse (press_pulse),
    .debounced   (debounced)
  );

  always #5 clock = ~clock;

  // advance one rising edge, then settle 1 ns before sampling / driving
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic cw, input logic pp, input logic db);
    check({tag, "_car_waiting"}, 32'(car_waiting), 32'(cw));
    check({tag, "_press_pulse"}, 32'(press_pulse), 32'(pp));
    check({tag, "_debounced"},   32'(debounced),   32'(db));
  endtask

  initial begin
    reset_n = 1'b0;
    key_n   = 1'b1;
    clear   = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("reset_state", 32'(dut.state_q), 32'(RELEASED));
    reset_n = 1'b1;
    tick(); tick();

    // Clean press: pulse exactly on edge 7 after key_n is first sampled low
    key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("clean_pp_e%0d", i), 32'(press_pulse), 32'(i == 7));
      if (i == 6 || i == 7 || i == 20)
        check_out($sformatf("clean_e%0d", i), i >= 7, i == 7, i >= 7);
    end

    // Clean release: debounced falls on edge 7 after the first high sample
    key_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("rel_db_e%0d", i), 32'(debounced), 32'(i < 7));
      check($sformatf("rel_pp_e%0d", i), 32'(press_pulse), 32'h0);
    end
    check("rel_cw_held", 32'(car_waiting), 32'h1);

    // Clear handshake, then clear while idle has no effect
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_cw", 32'(car_waiting), 32'h0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_again_cw", 32'(car_waiting), 32'h0);
    tick();

    // Bounce: low 3, high 1, low 2, high -> counter never reaches 3
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      key_n = (i <= 3 || i == 5 || i == 6) ? 1'b0 : 1'b1;
      tick();
      pulses += int'(press_pulse);
    end
    check("bounce_pulses", 32'(pulses), 32'h0);
    check_out("bounce", 1'b0, 1'b0, 1'b0);
    check("bounce_state", 32'(dut.state_q), 32'(RELEASED));

    // Held 30 cycles, then release bounce high 2 / low 1 / high 10
    pulses = 0;
    key_n  = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      pulses += int'(press_pulse);
    end
    check("held_pulses", 32'(pulses), 32'h1);
    check("held_db", 32'(debounced), 32'h1);
    // last rise is first sampled on edge 4; debounced falls on edge 10
    for (int i = 1; i <= 13; i++) begin
      key_n = (i == 3) ? 1'b0 : 1'b1;
      tick();
      pulses += int'(press_pulse);
      check($sformatf("relb_db_e%0d", i), 32'(debounced), 32'(i < 10));
    end
    check("relb_pulses", 32'(pulses), 32'h1);
    check("relb_cw", 32'(car_waiting), 32'h1);

    // Set/clear collision: clear lands on the press_pulse edge
    clear = 1'b1; tick(); clear = 1'b0;
    check("coll_pre_cw", 32'(car_waiting), 32'h0);
    key_n = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_out("coll_e7", 1'b1, 1'b1, 1'b1);
    tick();
    check_out("coll_e8", 1'b1, 1'b0, 1'b1);

    // Repeated press while request pending still pulses
    key_n = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    check("rep_rel_db", 32'(debounced), 32'h0);
    key_n = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    check_out("rep_e7", 1'b1, 1'b1, 1'b1);
    key_n = 1'b1;
    for (int i = 1; i <= 10; i++) tick();

    // Reset in PRESS_CHK with counter at 2, key_n held low across it
    key_n = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check("mid_state", 32'(dut.state_q), 32'(PRESS_CHK));
    check("mid_cnt", 32'(dut.cnt_q), 32'h2);
    reset_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check_out("mid_rst_hold", 1'b0, 1'b0, 1'b0);
    check("mid_rst_state", 32'(dut.state_q), 32'(RELEASED));
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("requal_pp_e%0d", i), 32'(press_pulse), 32'(i == 7));
    end
    check_out("requal_end", 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
